// File: rtl/axis_receiver_pkg.sv
// Shared parameters for the AXI-Stream receive path.
// Holds the link field widths, the FIFO sizing and the receiver state encoding.
package axis_receiver_pkg;

    // Payload width kept from the stream and the buffer depth
    localparam int DATAW          = 16;
    localparam int FIFO_DEPTH     = 4;

    // AXI-Stream sideband and data widths on the NoC side
    localparam int AXIS_DESTW     = 4;
    localparam int AXIS_IDW       = 4;
    localparam int AXIS_STRBW     = 4;
    localparam int AXIS_KEEPW     = 4;
    localparam int AXIS_USERW     = 2;
    localparam int AXIS_MAX_DATAW = 32;

    // Receiver state encoding: RECV=0, CLOSING=1, DONE=2
    typedef enum logic [1:0] {
        RX_RECV    = 2'd0,
        RX_CLOSING = 2'd1,
        RX_DONE    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/axis_receiver_fifo.sv
// First-word-fall-through FIFO used to buffer received beats.
// The head entry is visible on rd_data whenever empty is low.
// Writes into a full FIFO and reads from an empty one are ignored.
module axis_receiver_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry an extra wrap bit so full and empty can be told apart
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers, cleared by reset to flush the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_receiver.sv
// Receive end of the AXI-Stream link.
// Buffers payload plus tlast in a FIFO and hands beats to a local consumer.
// The receiver closes on a stored tlast beat, drains, then raises a sticky done.
// Optional feature macro: SRC_CHECK_EN drops beats whose tuser differs from EXPECTED_SRC.
module axis_receiver
    import axis_receiver_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DATAW,
    parameter int                    DEPTH        = FIFO_DEPTH,
    parameter logic [AXIS_USERW-1:0] EXPECTED_SRC = 2'b11,
    parameter int                    CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axis_rx_tvalid,
    output logic                      axis_rx_tready,
    input  logic                      axis_rx_tlast,
    input  logic [AXIS_DESTW-1:0]     axis_rx_tdest,
    input  logic [AXIS_IDW-1:0]       axis_rx_tid,
    input  logic [AXIS_STRBW-1:0]     axis_rx_tstrb,
    input  logic [AXIS_KEEPW-1:0]     axis_rx_tkeep,
    input  logic [AXIS_USERW-1:0]     axis_rx_tuser,
    input  logic [AXIS_MAX_DATAW-1:0] axis_rx_tdata,
    output logic [DATA_WIDTH-1:0]     rx_tdata,
    output logic                      rx_tlast,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_done,
    output logic [CNT_W-1:0]          rx_beat_count,
    output logic [CNT_W-1:0]          rx_drop_count
);

    rx_state_t           state;
    rx_state_t           state_next;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;
    logic                acc;
    logic                src_ok;
    logic                push;
    logic                pop;
    logic                unused_sideband;

    // Routing sideband and the upper payload bits carry nothing for this receiver
    assign unused_sideband = ^{axis_rx_tdest, axis_rx_tid, axis_rx_tstrb, axis_rx_tkeep,
                               axis_rx_tdata[AXIS_MAX_DATAW-1:DATA_WIDTH]};

    // Handshake: tready depends only on state and FIFO space, never on tvalid
    assign axis_rx_tready = (state == RX_RECV) && !fifo_full;
    assign acc            = axis_rx_tvalid && axis_rx_tready;
    assign push           = acc && src_ok;

    // Consumer side: head of FIFO is presented directly, zeroed when nothing is valid
    assign rx_valid = !fifo_empty && (state != RX_DONE);
    assign pop      = rx_valid && rx_ready;
    assign rx_tdata = rx_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign rx_tlast = rx_valid && fifo_head[DATA_WIDTH];
    assign rx_done  = (state == RX_DONE);

    axis_receiver_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({axis_rx_tlast, axis_rx_tdata[DATA_WIDTH-1:0]}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

`ifdef SRC_CHECK_EN
    // Beats from an unexpected source complete the handshake but are discarded
    assign src_ok = (axis_rx_tuser == EXPECTED_SRC);

    // Saturating count of discarded beats
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_drop_count <= '0;
        end else if (acc && !src_ok && (rx_drop_count != {CNT_W{1'b1}})) begin
            rx_drop_count <= rx_drop_count + CNT_W'(1);
        end
    end
`else
    logic unused_tuser;

    assign src_ok        = 1'b1;
    assign rx_drop_count = '0;
    assign unused_tuser  = ^axis_rx_tuser;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_RECV;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: close on a stored tlast beat, finish when it is consumed
    always_comb begin
        state_next = state;
        case (state)
            RX_RECV: begin
                if (push && axis_rx_tlast) begin
                    state_next = RX_CLOSING;
                end
            end
            RX_CLOSING: begin
                if (pop && rx_tlast) begin
                    state_next = RX_DONE;
                end
            end
            RX_DONE: begin
                state_next = RX_DONE;
            end
            default: begin
                state_next = RX_RECV;
            end
        endcase
    end

    // Saturating count of beats written into the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_beat_count <= '0;
        end else if (push && (rx_beat_count != {CNT_W{1'b1}})) begin
            rx_beat_count <= rx_beat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_receiver.sv
// Self-checking bench for axis_receiver: a directed vector table, hand-written
// corner sequences, and randomized traffic checked against a queue-based model.
module tb_axis_receiver;
    import axis_receiver_pkg::*;

    localparam int DW = DATAW;
    localparam int D  = FIFO_DEPTH;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      axis_rx_tvalid;
    logic                      axis_rx_tready;
    logic                      axis_rx_tlast;
    logic [AXIS_DESTW-1:0]     axis_rx_tdest;
    logic [AXIS_IDW-1:0]       axis_rx_tid;
    logic [AXIS_STRBW-1:0]     axis_rx_tstrb;
    logic [AXIS_KEEPW-1:0]     axis_rx_tkeep;
    logic [AXIS_USERW-1:0]     axis_rx_tuser;
    logic [AXIS_MAX_DATAW-1:0] axis_rx_tdata;
    logic [DW-1:0]             rx_tdata;
    logic                      rx_tlast;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      rx_done;
    logic [31:0]               rx_beat_count;
    logic [31:0]               rx_drop_count;

    axis_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .axis_rx_tvalid (axis_rx_tvalid),
        .axis_rx_tready (axis_rx_tready),
        .axis_rx_tlast  (axis_rx_tlast),
        .axis_rx_tdest  (axis_rx_tdest),
        .axis_rx_tid    (axis_rx_tid),
        .axis_rx_tstrb  (axis_rx_tstrb),
        .axis_rx_tkeep  (axis_rx_tkeep),
        .axis_rx_tuser  (axis_rx_tuser),
        .axis_rx_tdata  (axis_rx_tdata),
        .rx_tdata       (rx_tdata),
        .rx_tlast       (rx_tlast),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_done        (rx_done),
        .rx_beat_count  (rx_beat_count),
        .rx_drop_count  (rx_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          tv;
        logic          tl;
        logic [DW-1:0] td;
        logic          rr;
        logic          eReady;
        logic          eValid;
        logic [DW-1:0] eData;
        logic          eLast;
        logic          eDone;
        int            eCount;
    } vec_t;

    vec_t          vecs [7];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] recvq [$];
    logic          lastAcc;

    // Reference model state for the randomized phase
    logic [DW:0]   mq [$];
    logic          mClosed;
    logic          mDone;
    int            mCount;
    int            mDrops;
    int            doneAge;
    logic          expReady;
    logic          expValid;
    logic          srcOk;
    logic          rTv;
    logic          rTl;
    logic [DW-1:0] rTd;
    logic [1:0]    rTu;
    logic          rRr;
    int            k;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic tv, input logic tl, input logic [DW-1:0] td,
                                 input logic [AXIS_USERW-1:0] tu, input logic rr);
        axis_rx_tvalid = tv;
        axis_rx_tlast  = tl;
        axis_rx_tdata  = $urandom;
        axis_rx_tdata[DW-1:0] = td;
        axis_rx_tuser  = tu;
        axis_rx_tdest  = AXIS_DESTW'($urandom);
        axis_rx_tid    = AXIS_IDW'($urandom);
        axis_rx_tstrb  = AXIS_STRBW'($urandom);
        axis_rx_tkeep  = AXIS_KEEPW'($urandom);
        rx_ready       = rr;
    endtask

    // Observe the handshakes of the current cycle, then advance to the next negedge
    task automatic tick();
        #1;
        lastAcc = axis_rx_tvalid && axis_rx_tready;
        if (rx_valid && rx_ready) recvq.push_back(rx_tdata);
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, 2'b11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        recvq.delete();
    endtask

    task automatic drainUntilDone(input string name);
        for (int c = 0; c < 40 && !rx_done; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 2'b11, 1'b1);
            tick();
        end
        checkOutput({name, "_done"}, rx_done, 1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 2'b11, 1'b0);
        lastAcc = 1'b0;

        //                 tv tl td  rr | rdy vld data last done count
        vecs[0] = '{1'b1, 1'b0, 16'd10, 1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 16'd20, 1'b1, 1'b1, 1'b1, 16'd10, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 16'd30, 1'b1, 1'b1, 1'b1, 16'd20, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 16'd40, 1'b1, 1'b1, 1'b1, 16'd30, 1'b0, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b0, 16'd99, 1'b1, 1'b0, 1'b1, 16'd40, 1'b1, 1'b0, 4};
        vecs[5] = '{1'b1, 1'b0, 16'd55, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 4};
        vecs[6] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 4};

        // Reset state
        doReset();
        checkOutput("rst_tready", axis_rx_tready, 1);
        checkOutput("rst_valid", rx_valid, 0);
        checkOutput("rst_done", rx_done, 0);
        checkOutput("rst_beats", rx_beat_count, 0);
        checkOutput("rst_drops", rx_drop_count, 0);

        // Four-beat transfer from the vector table
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("vec%0d_tready", i), axis_rx_tready, vecs[i].eReady);
            checkOutput($sformatf("vec%0d_valid", i), rx_valid, vecs[i].eValid);
            checkOutput($sformatf("vec%0d_data", i), rx_tdata, vecs[i].eData);
            checkOutput($sformatf("vec%0d_last", i), rx_tlast, vecs[i].eLast);
            checkOutput($sformatf("vec%0d_done", i), rx_done, vecs[i].eDone);
            checkOutput($sformatf("vec%0d_count", i), rx_beat_count, vecs[i].eCount);
            applyStimulus(vecs[i].tv, vecs[i].tl, vecs[i].td, 2'b11, vecs[i].rr);
            tick();
        end
        checkOutput("vec_recv_size", recvq.size(), 4);
        for (int i = 0; i < 4 && i < recvq.size(); i++)
            checkOutput($sformatf("vec_recv%0d", i), recvq[i], 10 * (i + 1));

        // Backpressure: DEPTH+2 beats against a stalled consumer
        doReset();
        k = 0;
        for (int c = 0; c < D + 2; c++) begin
            applyStimulus(1'b1, k == D + 1, DW'(100 + k), 2'b11, 1'b0);
            tick();
            if (lastAcc) k++;
        end
        checkOutput("bp_count", rx_beat_count, D);
        checkOutput("bp_tready", axis_rx_tready, 0);
        checkOutput("bp_accepted", k, D);
        for (int c = 0; c < 40 && k < D + 2; c++) begin
            applyStimulus(1'b1, k == D + 1, DW'(100 + k), 2'b11, 1'b1);
            tick();
            if (lastAcc) k++;
        end
        drainUntilDone("bp");
        checkOutput("bp_final_count", rx_beat_count, D + 2);
        checkOutput("bp_recv_size", recvq.size(), D + 2);
        for (int i = 0; i < D + 2 && i < recvq.size(); i++)
            checkOutput($sformatf("bp_recv%0d", i), recvq[i], 100 + i);

        // Single-beat transfer closes immediately
        doReset();
        applyStimulus(1'b1, 1'b1, 16'd7, 2'b11, 1'b0);
        tick();
        checkOutput("single_tready", axis_rx_tready, 0);
        checkOutput("single_valid", rx_valid, 1);
        checkOutput("single_data", rx_tdata, 7);
        checkOutput("single_last", rx_tlast, 1);
        checkOutput("single_done_early", rx_done, 0);
        applyStimulus(1'b1, 1'b0, 16'd8, 2'b11, 1'b1);
        tick();
        checkOutput("single_done", rx_done, 1);
        checkOutput("single_valid_after", rx_valid, 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, DW'(9 + c), 2'b11, 1'b1);
            tick();
            checkOutput($sformatf("single_noacc%0d", c), lastAcc, 0);
        end
        checkOutput("single_count", rx_beat_count, 1);

        // Reset with beats buffered, then a fresh transfer
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, DW'(50 + c), 2'b11, 1'b0);
            tick();
        end
        checkOutput("midrst_count_before", rx_beat_count, 3);
        applyStimulus(1'b0, 1'b0, '0, 2'b11, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", rx_valid, 0);
        checkOutput("midrst_count", rx_beat_count, 0);
        checkOutput("midrst_tready", axis_rx_tready, 1);
        recvq.delete();
        applyStimulus(1'b1, 1'b0, 16'd1, 2'b11, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 16'd2, 2'b11, 1'b1);
        tick();
        drainUntilDone("midrst");
        checkOutput("midrst_recv_size", recvq.size(), 2);
        if (recvq.size() == 2) begin
            checkOutput("midrst_recv0", recvq[0], 1);
            checkOutput("midrst_recv1", recvq[1], 2);
        end

`ifdef SRC_CHECK_EN
        // Source filtering: foreign beat is swallowed without closing
        doReset();
        applyStimulus(1'b1, 1'b0, 16'd1, 2'b11, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 16'd2, 2'b01, 1'b0);
        tick();
        checkOutput("src_drop", rx_drop_count, 1);
        checkOutput("src_open", axis_rx_tready, 1);
        applyStimulus(1'b1, 1'b1, 16'd3, 2'b11, 1'b0);
        tick();
        checkOutput("src_closed", axis_rx_tready, 0);
        checkOutput("src_beats", rx_beat_count, 2);
        drainUntilDone("src");
        checkOutput("src_recv_size", recvq.size(), 2);
        if (recvq.size() == 2) begin
            checkOutput("src_recv0", recvq[0], 1);
            checkOutput("src_recv1", recvq[1], 3);
        end
`endif

        // Randomized traffic against a queue-level model
        doReset();
        mq.delete();
        mClosed = 1'b0;
        mDone   = 1'b0;
        mCount  = 0;
        mDrops  = 0;
        doneAge = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (mDone && doneAge >= 2) begin
                doReset();
                mq.delete();
                mClosed = 1'b0;
                mDone   = 1'b0;
                mCount  = 0;
                mDrops  = 0;
                doneAge = 0;
            end
            expReady = !mClosed && (mq.size() < D);
            expValid = (mq.size() > 0) && !mDone;
            checkOutput("rnd_tready", axis_rx_tready, expReady);
            checkOutput("rnd_valid", rx_valid, expValid);
            checkOutput("rnd_data", rx_tdata, expValid ? mq[0][DW-1:0] : '0);
            checkOutput("rnd_last", rx_tlast, expValid ? mq[0][DW] : 1'b0);
            checkOutput("rnd_done", rx_done, mDone);
            checkOutput("rnd_beats", rx_beat_count, mCount);
            checkOutput("rnd_drops", rx_drop_count, mDrops);

            rTv = ($urandom_range(0, 3) != 0);
            rTl = ($urandom_range(0, 9) == 0);
            rTd = DW'($urandom);
            rTu = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rRr = ($urandom_range(0, 3) != 0);
            applyStimulus(rTv, rTl, rTd, rTu, rRr);
            tick();

`ifdef SRC_CHECK_EN
            srcOk = (rTu == 2'b11);
`else
            srcOk = 1'b1;
`endif
            if (mDone) doneAge++;
            if (expValid && rRr) begin
                if (mq[0][DW]) mDone = 1'b1;
                void'(mq.pop_front());
            end
            if (rTv && expReady) begin
                if (srcOk) begin
                    mq.push_back({rTl, rTd});
                    mCount++;
                    if (rTl) mClosed = 1'b1;
                end else begin
                    mDrops++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
